// File: rtl/iter_div_unit_pkg.sv
// rtl/iter_div_unit_pkg.sv - op and state encodings shared by the divider and the ALU select decode
package iter_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } div_state_e;

  localparam int WORD_WIDTH = 32;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/iter_div_unit_if.sv
// rtl/iter_div_unit_if.sv - request/response bundle between the pipeline and the divider
interface iter_div_unit_if #(
  parameter int BUS_WIDTH    = 64,
  parameter int DIV_OP_WIDTH = 2
) ();
  logic                    start;
  logic                    flush;
  logic [DIV_OP_WIDTH-1:0] op;
  logic                    word_mode;
  logic [BUS_WIDTH-1:0]    in1;
  logic [BUS_WIDTH-1:0]    in2;
  logic                    div_stall;
  logic                    busy;
  logic                    done;
  logic [BUS_WIDTH-1:0]    result;

  modport master (
    output start, flush, op, word_mode, in1, in2,
    input  div_stall, busy, done, result
  );

  modport slave (
    input  start, flush, op, word_mode, in1, in2,
    output div_stall, busy, done, result
  );
endinterface

// File: rtl/iter_div_unit_div_step.sv
// rtl/iter_div_unit_div_step.sv - one restoring shift-subtract iteration on unsigned magnitudes
module div_step #(
  parameter int W = 64
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic [W-1:0] quo_out
);
  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_in < divisor always, so diff[W] is a clean borrow flag
  always_comb begin
    shifted = (rem_in << 1) | {{W{1'b0}}, quo_in[W-1]};
    diff    = shifted - {1'b0, divisor};
    rem_out = diff[W] ? shifted : diff;
    quo_out = {quo_in[W-2:0], ~diff[W]};
  end
endmodule

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - iterative restoring divider, one quotient bit per cycle
module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int DIV_OP_WIDTH = 2
) (
  input logic            clk,
  input logic            rst,
  iter_div_unit_if.slave bus
);
  localparam int CW = $clog2(BUS_WIDTH) + 1;
  localparam int UPPER = BUS_WIDTH - WORD_WIDTH;
  localparam logic [BUS_WIDTH-1:0] MIN_NEG = {1'b1, {(BUS_WIDTH-1){1'b0}}};

  div_state_e state, state_nxt;

  logic [BUS_WIDTH:0]   rem_q, rem_nxt;
  logic [BUS_WIDTH-1:0] quo_q, quo_nxt, dvs_q, result_q;
  logic [CW-1:0]        cnt_q;
  logic                 is_rem_q, word_q, neg_quo_q, neg_rem_q, done_q;

  div_op_e              op_dec;
  logic                 word_eff, sgn, neg_a, neg_b, div_zero, ovf, special, accept;
  logic [BUS_WIDTH-1:0] in1_hi, in2_hi, a_ext, b_ext, mag_a, mag_b, quo_init;
  logic [CW-1:0]        n_steps;
  logic [BUS_WIDTH-1:0] fin_raw, fin_cor, fin_hi, fin_val;

  // Operand decode: word ops reduce to bits [31:0], sign- or zero-extended
  always_comb begin
    op_dec   = div_op_e'(bus.op[1:0]);
    word_eff = (UPPER > 0) && bus.word_mode;
    sgn      = op_is_signed(op_dec);
    in1_hi   = bus.in1 << UPPER;
    in2_hi   = bus.in2 << UPPER;
    a_ext    = bus.in1;
    b_ext    = bus.in2;
    if (word_eff) begin
      if (sgn) begin
        a_ext = $signed(in1_hi) >>> UPPER;
        b_ext = $signed(in2_hi) >>> UPPER;
      end else begin
        a_ext = in1_hi >> UPPER;
        b_ext = in2_hi >> UPPER;
      end
    end
    neg_a    = sgn && a_ext[BUS_WIDTH-1];
    neg_b    = sgn && b_ext[BUS_WIDTH-1];
    mag_a    = neg_a ? '0 - a_ext : a_ext;
    mag_b    = neg_b ? '0 - b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = sgn && (b_ext == '1) &&
               (word_eff ? (bus.in1[WORD_WIDTH-1:0] == 32'h8000_0000) : (a_ext == MIN_NEG));
    special  = div_zero || ovf;
    accept   = (state == ST_IDLE) && bus.start && !bus.flush;
    n_steps  = word_eff ? CW'(WORD_WIDTH) : CW'(BUS_WIDTH);
    // Word dividends sit in the top half so the shared step shifts them out first
    quo_init = word_eff ? (mag_a << UPPER) : mag_a;
  end

  div_step #(.W(BUS_WIDTH)) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_comb begin
    fin_raw = is_rem_q ? rem_q[BUS_WIDTH-1:0] : quo_q;
    fin_cor = (is_rem_q ? neg_rem_q : neg_quo_q) ? '0 - fin_raw : fin_raw;
    fin_hi  = fin_cor << UPPER;
    fin_val = fin_cor;
    if (word_q) begin
      fin_val = $signed(fin_hi) >>> UPPER;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (bus.start) state_nxt = special ? ST_FINISH : ST_CALC;
        ST_CALC:   if (cnt_q == CW'(1)) state_nxt = ST_FINISH;
        ST_FINISH: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Special cases preload the final raw value with sign flags cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      word_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            is_rem_q <= op_is_rem(op_dec);
            word_q   <= word_eff;
            dvs_q    <= mag_b;
            if (div_zero) begin
              quo_q     <= '1;
              rem_q     <= {1'b0, a_ext};
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              cnt_q     <= '0;
            end else if (ovf) begin
              quo_q     <= a_ext;
              rem_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              cnt_q     <= '0;
            end else begin
              quo_q     <= quo_init;
              rem_q     <= '0;
              neg_quo_q <= neg_a ^ neg_b;
              neg_rem_q <= neg_a;
              cnt_q     <= n_steps;
            end
          end
        end
        ST_CALC: begin
          if (!bus.flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FINISH: begin
          if (!bus.flush) begin
            result_q <= fin_val;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = rst && (state != ST_IDLE);
  assign bus.div_stall = rst && (accept || (state == ST_CALC));
  assign bus.done      = done_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_iter_div_unit.sv
// tb/tb_iter_div_unit.sv - self-checking bench for iter_div_unit against an arithmetic reference model
module tb_iter_div_unit;
  localparam int BW = 64;
  localparam logic [1:0] F_DIV = 2'b00, F_DIVU = 2'b01, F_REM = 2'b10, F_REMU = 2'b11;

  logic        clk;
  logic        rst;
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] last_res = '0;

  iter_div_unit_if #(.BUS_WIDTH(BW), .DIV_OP_WIDTH(2)) bus ();

  iter_div_unit #(.BUS_WIDTH(BW), .DIV_OP_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain signed/unsigned arithmetic
  task automatic ref_model(input logic [1:0] op, input bit w, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] r, output int lat);
    logic signed [63:0] sa, sb, smin;
    logic [63:0]        ua, ub;
    bit                 sgn, rem, ovf;
    sgn = (op == F_DIV) || (op == F_REM);
    rem = (op == F_REM) || (op == F_REMU);
    if (w) begin
      sa   = $signed({{32{a[31]}}, a[31:0]});
      sb   = $signed({{32{b[31]}}, b[31:0]});
      ua   = {32'd0, a[31:0]};
      ub   = {32'd0, b[31:0]};
      smin = -64'sd2147483648;
    end else begin
      sa   = $signed(a);
      sb   = $signed(b);
      ua   = a;
      ub   = b;
      smin = $signed(64'h8000_0000_0000_0000);
    end
    ovf = sgn && (sa == smin) && (sb == -64'sd1);
    if (ub == 64'd0)  r = rem ? (sgn ? sa : ua) : '1;
    else if (ovf)     r = rem ? 64'd0 : sa;
    else if (sgn)     r = rem ? sa % sb : sa / sb;
    else              r = rem ? ua % ub : ua / ub;
    if (w) r = {{32{r[31]}}, r[31:0]};
    lat = ((ub == 64'd0) || ovf) ? 1 : (w ? 33 : 65);
  endtask

  task automatic run_op(input logic [1:0] op, input bit w, input logic [63:0] a, input logic [63:0] b,
                        input int poke_c, input int flush_c,
                        output logic [63:0] res, output int lat, output int stalls,
                        output bit got, output bit idle_after_flush);
    int limit;
    res = '0; lat = -1; stalls = 0; got = 1'b0; idle_after_flush = 1'b0;
    limit = (flush_c >= 0) ? flush_c + 2 : 100;
    @(negedge clk);
    bus.op = op; bus.word_mode = w; bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
    #1 if (bus.div_stall === 1'b1) stalls++;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c <= limit && !got; c++) begin
      @(negedge clk);
      if (bus.div_stall === 1'b1) stalls++;
      if (bus.done === 1'b1) begin
        got = 1'b1; lat = c; res = bus.result;
      end
      if (flush_c >= 0 && c == flush_c + 1) idle_after_flush = (bus.busy === 1'b0);
      bus.start = (c == poke_c);
      bus.flush = (c == flush_c);
      if (c == poke_c) bus.in1 = ~a;
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input bit w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] want, input bit use_model, input int poke_c);
    logic [63:0] res, mres, exp;
    int          lat, stalls, exp_lat;
    bit          got, idle;
    ref_model(op, w, a, b, mres, exp_lat);
    exp = use_model ? mres : want;
    run_op(op, w, a, b, poke_c, -1, res, lat, stalls, got, idle);
    check({tag, " result"}, res, exp);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
    @(negedge clk);
    check({tag, " done width"}, {63'd0, bus.done}, 64'd0);
    check({tag, " result held"}, bus.result, exp);
    last_res = exp;
  endtask

  initial begin
    logic [63:0] res, a, b;
    logic [1:0]  op;
    bit          w, got, idle;
    int          lat, stalls, dones;

    rst = 1'b0;
    bus.start = 1'b1; bus.flush = 1'b0; bus.op = F_DIVU; bus.word_mode = 1'b0;
    bus.in1 = 64'd100; bus.in2 = 64'd7;
    #12;
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset stall", {63'd0, bus.div_stall}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset result", bus.result, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;

    do_op("divu 100/7", F_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, -1);
    do_op("remu 100/7", F_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, -1);
    do_op("div -7/2", F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, -1);
    do_op("rem -7/2", F_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1);
    do_op("div 7/-2", F_DIV, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, -1);
    do_op("div 5/0", F_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1);
    do_op("rem 5/0", F_REM, 1'b0, 64'd5, 64'd0, 64'd5, 1'b0, -1);
    do_op("div min/-1", F_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1'b0, -1);
    do_op("rem min/-1", F_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, -1);
    do_op("divw min/-1", F_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1'b0, -1);
    do_op("divuw upper ignored", F_DIVU, 1'b1, 64'hDEAD_0000_0000_0064, 64'd10, 64'd10, 1'b0, -1);
    do_op("start while busy", F_DIVU, 1'b0, 64'd1000, 64'd3, 64'd333, 1'b0, 5);

    // flush and start in the same cycle: flush wins
    @(negedge clk);
    bus.op = F_DIVU; bus.word_mode = 1'b0; bus.in1 = 64'd50; bus.in2 = 64'd5;
    bus.start = 1'b1; bus.flush = 1'b1;
    #1 check("flush beats start stall", {63'd0, bus.div_stall}, 64'd0);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    check("flush beats start busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    check("flush beats start done", {63'd0, bus.done}, 64'd0);

    run_op(F_DIVU, 1'b0, 64'd1000, 64'd7, -1, 20, res, lat, stalls, got, idle);
    check("flush no done", {63'd0, got}, 64'd0);
    check("flush idle next edge", {63'd0, idle}, 64'd1);
    check("flush result unchanged", bus.result, last_res);
    do_op("after flush", F_DIVU, 1'b0, 64'd1000, 64'd7, 64'd142, 1'b0, -1);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.op = F_DIVU; bus.word_mode = 1'b0; bus.in1 = 64'd1000; bus.in2 = 64'd3; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("busy before reset", {63'd0, bus.busy}, 64'd1);
    #1 rst = 1'b0;
    #1;
    check("mid reset busy", {63'd0, bus.busy}, 64'd0);
    check("mid reset stall", {63'd0, bus.div_stall}, 64'd0);
    check("mid reset done", {63'd0, bus.done}, 64'd0);
    check("mid reset result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("no done after reset", 64'(dones), 64'd0);
    check("idle after reset", {63'd0, bus.busy}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0: b = w ? {$urandom(), 32'd0} : 64'd0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 15));
        3: begin
          a = w ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom(), 32'hFFFF_FFFF} : '1;
        end
        4: b = 64'($urandom_range(1, 1000));
        default: ;
      endcase
      do_op("random", op, w, a, b, 64'd0, 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
